// File: rtl/ypbpr_pkg.sv
// Shared constants, control bundle and helpers for the YPbPr -> RGB decoder.
// The porch black-level clamp is enabled with YPBPR_BLACK_CLAMP_EN.
package ypbpr_pkg;

   localparam int COEF_R_CR  = 359;
   localparam int COEF_G_CB  = 88;
   localparam int COEF_G_CR  = 183;
   localparam int COEF_B_CB  = 454;
   localparam int CHROMA_MID = 128;
   localparam int PIPE_LAT   = 4;
   localparam int ROUND_HALF = 128;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SKIP   = 2'd1;
   localparam logic [1:0] ST_ACCUM  = 2'd2;
   localparam logic [1:0] ST_UPDATE = 2'd3;

   typedef struct packed {
      logic hs;
      logic vs;
      logic cs;
      logic de;
      logic en;
   } ctl_t;

   localparam ctl_t CTL_RST = '{
      hs: 1'b1,
      vs: 1'b1,
      cs: 1'b1,
      de: 1'b0,
      en: 1'b0
   };

   // Drop the 8 fractional bits, then saturate to an unsigned 8-bit code.
   function automatic logic [7:0] clamp_u8(input logic signed [18:0] v);
      logic signed [10:0] s;
      s = v[18:8];
      if (s < 0)
         return 8'd0;
      if (s > 11'sd255)
         return 8'hFF;
      return s[7:0];
   endfunction

endpackage

// File: rtl/ypbpr_black_clamp.sv
// Porch black-level estimator: skips a few samples after the csync rising
// edge, averages a power-of-two window of Y and latches it as black level.
module ypbpr_black_clamp
   import ypbpr_pkg::*;
#(
   parameter logic [7:0] Y_BLACK    = 8'd0,
   parameter int         CLAMP_SKIP = 4,
   parameter int         CLAMP_LOG2 = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_csync,
   input  logic       i_de,
   input  logic [7:0] i_y,
   output logic [7:0] o_black_level
);

   localparam int SUM_W = 8 + CLAMP_LOG2;
   localparam logic [3:0] SKIP_LAST = 4'(CLAMP_SKIP - 1);
   localparam logic [CLAMP_LOG2-1:0] ACC_LAST = '1;

   logic [1:0]            r_state;
   logic                  r_cs_d;
   logic [3:0]            r_scnt;
   logic [CLAMP_LOG2-1:0] r_acnt;
   logic [SUM_W-1:0]      r_sum;
   logic [7:0]            r_black;

   logic w_porch;
   logic w_rise;

   assign w_porch = i_csync & ~i_de;
   assign w_rise  = w_porch & ~r_cs_d;

   assign o_black_level = r_black;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cs_d  <= 1'b1;
         r_scnt  <= '0;
         r_acnt  <= '0;
         r_sum   <= '0;
         r_black <= Y_BLACK;
      end else begin
         r_cs_d <= i_csync;
         case (r_state)
            ST_IDLE: begin
               // The edge sample itself is the first skipped sample.
               if (w_rise) begin
                  r_scnt  <= 4'd1;
                  r_acnt  <= '0;
                  r_sum   <= '0;
                  r_state <= (CLAMP_SKIP == 1) ? ST_ACCUM : ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (!w_porch)
                  r_state <= ST_IDLE;
               else if (r_scnt == SKIP_LAST)
                  r_state <= ST_ACCUM;
               else
                  r_scnt <= r_scnt + 4'd1;
            end
            ST_ACCUM: begin
               if (!w_porch) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_sum  <= r_sum + SUM_W'(i_y);
                  r_acnt <= r_acnt + 1'b1;
                  if (r_acnt == ACC_LAST)
                     r_state <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               // Never move the black level inside active video.
               if (!i_de)
                  r_black <= r_sum[SUM_W-1:CLAMP_LOG2];
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ypbpr_to_rgb_decode.sv
// Four-stage BT.601 YPbPr -> full-range RGB decoder with matched sync delay.
// Define YPBPR_BLACK_CLAMP_EN to track black level from the back porch.
module ypbpr_to_rgb_decode
   import ypbpr_pkg::*;
#(
   parameter logic [7:0] Y_BLACK    = 8'd0,
   parameter int         CLAMP_SKIP = 4,
   parameter int         CLAMP_LOG2 = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ypbpr_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        csync,
   input  logic        de,
   input  logic [23:0] din,
   output logic [23:0] dout,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        csync_o,
   output logic        de_o,
   output logic [7:0]  black_level
);

   localparam logic signed [17:0] K_RCR = 18'(COEF_R_CR);
   localparam logic signed [17:0] K_GCB = 18'(COEF_G_CB);
   localparam logic signed [17:0] K_GCR = 18'(COEF_G_CR);
   localparam logic signed [17:0] K_BCB = 18'(COEF_B_CB);
   localparam logic signed [8:0]  K_MID = 9'(CHROMA_MID);
   localparam logic signed [18:0] K_RND = 19'(ROUND_HALF);

   logic [7:0] w_black;

`ifdef YPBPR_BLACK_CLAMP_EN
   ypbpr_black_clamp #(
      .Y_BLACK    (Y_BLACK),
      .CLAMP_SKIP (CLAMP_SKIP),
      .CLAMP_LOG2 (CLAMP_LOG2)
   ) u_clamp (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_csync       (csync),
      .i_de          (de),
      .i_y           (din[15:8]),
      .o_black_level (w_black)
   );
`else
   assign w_black = Y_BLACK;
`endif

   assign black_level = w_black;

   ctl_t w_ctl0;
   ctl_t r_ctl1, r_ctl2, r_ctl3;
   logic [23:0] r_din1, r_din2, r_din3;

   assign w_ctl0 = '{
      hs: hsync,
      vs: vsync,
      cs: csync,
      de: de,
      en: ypbpr_en
   };

   // Stage 1: black-level removal and chroma re-centering.
   logic signed [8:0] w_ydiff, w_yd, w_cb, w_cr;
   logic signed [8:0] r_yd, r_cb, r_cr;

   assign w_ydiff = $signed({1'b0, din[15:8]}) - $signed({1'b0, w_black});
   assign w_yd    = w_ydiff[8] ? 9'sd0 : w_ydiff;
   assign w_cb    = $signed({1'b0, din[7:0]}) - K_MID;
   assign w_cr    = $signed({1'b0, din[23:16]}) - K_MID;

   // Stage 2: coefficient products.
   logic signed [17:0] w_cb_x, w_cr_x;
   logic signed [17:0] r_ysh, r_p_rcr, r_p_gcb, r_p_gcr, r_p_bcb;

   assign w_cb_x = {{9{r_cb[8]}}, r_cb};
   assign w_cr_x = {{9{r_cr[8]}}, r_cr};

   // Stage 3: matrix sums with half-LSB rounding.
   logic signed [18:0] w_ysh, w_rcr, w_gcb, w_gcr, w_bcb;
   logic signed [18:0] r_sr, r_sg, r_sb;

   assign w_ysh = {r_ysh[17], r_ysh};
   assign w_rcr = {r_p_rcr[17], r_p_rcr};
   assign w_gcb = {r_p_gcb[17], r_p_gcb};
   assign w_gcr = {r_p_gcr[17], r_p_gcr};
   assign w_bcb = {r_p_bcb[17], r_p_bcb};

   // Stage 4: scale, saturate and mode select.
   logic [23:0] w_rgb;

   assign w_rgb = {clamp_u8(r_sr), clamp_u8(r_sg), clamp_u8(r_sb)};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctl1  <= CTL_RST;
         r_ctl2  <= CTL_RST;
         r_ctl3  <= CTL_RST;
         r_din1  <= '0;
         r_din2  <= '0;
         r_din3  <= '0;
         r_yd    <= '0;
         r_cb    <= '0;
         r_cr    <= '0;
         r_ysh   <= '0;
         r_p_rcr <= '0;
         r_p_gcb <= '0;
         r_p_gcr <= '0;
         r_p_bcb <= '0;
         r_sr    <= '0;
         r_sg    <= '0;
         r_sb    <= '0;
         dout    <= '0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
         csync_o <= 1'b1;
         de_o    <= 1'b0;
      end else begin
         r_ctl1 <= w_ctl0;
         r_ctl2 <= r_ctl1;
         r_ctl3 <= r_ctl2;
         r_din1 <= din;
         r_din2 <= r_din1;
         r_din3 <= r_din2;

         r_yd <= w_yd;
         r_cb <= w_cb;
         r_cr <= w_cr;

         r_ysh   <= {1'b0, r_yd, 8'd0};
         r_p_rcr <= w_cr_x * K_RCR;
         r_p_gcb <= w_cb_x * K_GCB;
         r_p_gcr <= w_cr_x * K_GCR;
         r_p_bcb <= w_cb_x * K_BCB;

         r_sr <= w_ysh + w_rcr + K_RND;
         r_sg <= w_ysh - w_gcb - w_gcr + K_RND;
         r_sb <= w_ysh + w_bcb + K_RND;

         if (!r_ctl3.en)
            dout <= r_din3;
         else if (!r_ctl3.de)
            dout <= '0;
         else
            dout <= w_rgb;

         hsync_o <= r_ctl3.hs;
         vsync_o <= r_ctl3.vs;
         csync_o <= r_ctl3.cs;
         de_o    <= r_ctl3.de;
      end
   end

endmodule

// File: tb/tb_ypbpr_to_rgb_decode.sv
// Scoreboard bench for ypbpr_to_rgb_decode: driver queues expected outputs
// from an arithmetic BT.601 model, a monitor pops them as the pipe delivers.
`timescale 1ns/1ps
module tb_ypbpr_to_rgb_decode;

   localparam logic [7:0] Y_BLACK = 8'd0;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ypbpr_en = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        csync = 1'b1;
   logic        de = 1'b0;
   logic [23:0] din = '0;
   logic [23:0] dout;
   logic        hsync_o, vsync_o, csync_o, de_o;
   logic [7:0]  black_level;

   always #5 clk = ~clk;

   ypbpr_to_rgb_decode dut (
      .clk         (clk),
      .reset       (reset),
      .ypbpr_en    (ypbpr_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .csync       (csync),
      .de          (de),
      .din         (din),
      .dout        (dout),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .csync_o     (csync_o),
      .de_o        (de_o),
      .black_level (black_level)
   );

   typedef struct {
      int          due;
      logic [23:0] dout;
      logic [3:0]  sy;
      logic        chk_bl;
      logic [7:0]  bl;
      int          tid;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   m_black = int'(Y_BLACK);
   int   tid = 0;

   function automatic int sat8(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic logic [23:0] model(input logic en, input logic d,
                                         input logic [23:0] x, input int blk);
      int y, cb, cr, r, g, b;
      if (!en) return x;
      if (!d) return 24'h0;
      y = int'(x[15:8]) - blk;
      if (y < 0) y = 0;
      cb = int'(x[7:0]) - 128;
      cr = int'(x[23:16]) - 128;
      r = sat8((y * 256 + 359 * cr + 128) >>> 8);
      g = sat8((y * 256 - 88 * cb - 183 * cr + 128) >>> 8);
      b = sat8((y * 256 + 454 * cb + 128) >>> 8);
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   // csync stays high outside the clamp test so the estimator never starts.
   function automatic logic rnd_cs();
`ifdef YPBPR_BLACK_CLAMP_EN
      return 1'b1;
`else
      return 1'($urandom_range(0, 1));
`endif
   endfunction

   task automatic drive(input logic en, input logic d, input logic hs,
                        input logic vs, input logic cs, input logic [23:0] x);
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      ypbpr_en = en;
      de = d;
      hsync = hs;
      vsync = vs;
      csync = cs;
      din = x;
      e.due = cyc + LAT;
      e.dout = model(en, d, x, m_black);
      e.sy = {hs, vs, cs, d};
      e.chk_bl = 1'b0;
      e.bl = 8'h00;
      e.tid = tid;
      q.push_back(e);
   endtask

   task automatic drive_rand(input int n);
      for (int i = 0; i < n; i++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rnd_cs(), 24'($urandom));
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         ypbpr_en = 1'($urandom_range(0, 1));
         de = 1'($urandom_range(0, 1));
         hsync = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
         csync = rnd_cs();
         din = 24'($urandom);
         while (q.size() > 0 && q[q.size()-1].due > cyc)
            q.delete(q.size() - 1);
         e.due = cyc + 1;
         e.dout = 24'h0;
         e.sy = 4'b1110;
         e.chk_bl = 1'b1;
         e.bl = Y_BLACK;
         e.tid = tid;
         q.push_back(e);
      end
      m_black = int'(Y_BLACK);
   endtask

   task automatic check_bl(input string nm, input logic [7:0] want);
      checks++;
      if (black_level !== want) begin
         errors++;
         $display("FAIL %s black_level got=%h want=%h", nm, black_level, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc ||
                dout !== e.dout ||
                {hsync_o, vsync_o, csync_o, de_o} !== e.sy ||
                (e.chk_bl && black_level !== e.bl)) begin
               errors++;
               $display("FAIL t%0d cyc=%0d got dout=%h hvcd=%b bl=%h want dout=%h hvcd=%b bl=%h",
                        e.tid, cyc, dout, {hsync_o, vsync_o, csync_o, de_o},
                        black_level, e.dout, e.sy, e.bl);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      do_reset(2);

      tid = 2;
      drive(1, 1, 1, 1, 1, 24'h80EB80);
      drive(1, 1, 1, 1, 1, 24'h800080);

      tid = 3;
      drive(1, 1, 1, 1, 1, {8'hFF, 8'h4C, 8'h55});
      drive(1, 1, 0, 1, 1, {8'hFF, 8'hFF, 8'h80});
      drive(1, 1, 1, 0, 1, {8'h00, 8'h00, 8'h80});
      drive(1, 1, 1, 1, 1, {8'h80, 8'hFF, 8'hFF});
      drive(1, 1, 1, 1, 1, {8'h00, 8'h80, 8'h00});

      tid = 4;
      drive(0, 0, 1, 1, 1, 24'h123456);
      drive(0, 1, 1, 1, 1, 24'h123456);
      drive(1, 0, 0, 0, 1, 24'h80EB80);
      drive(0, 1, 1, 0, 1, 24'hABCDEF);
      drive(1, 1, 1, 1, 1, 24'hABCDEF);

      tid = 6;
      drive_rand(200);
      check_bl("const_black", Y_BLACK);

      tid = 1;
      do_reset(2);
      tid = 7;
      drive_rand(60);

`ifdef YPBPR_BLACK_CLAMP_EN
      tid = 5;
      repeat (3) drive(1, 0, 1, 1, 0, {8'h80, 8'hC8, 8'h80});
      repeat (4) drive(1, 0, 1, 1, 1, {8'h80, 8'hC8, 8'h80});
      repeat (16) drive(1, 0, 1, 1, 1, {8'h80, 8'h6D, 8'h80});
      repeat (3) drive(1, 0, 1, 1, 1, {8'h80, 8'h6D, 8'h80});
      @(negedge clk);
      check_bl("clamp_update", 8'h6D);
      m_black = 'h6D;
      drive(1, 1, 1, 1, 1, {8'h80, 8'h6D, 8'h80});
      drive(1, 1, 1, 1, 1, {8'h80, 8'hFF, 8'h80});
      drive(1, 0, 1, 1, 1, {8'h80, 8'h20, 8'h80});

      tid = 8;
      repeat (3) drive(1, 0, 1, 1, 0, {8'h80, 8'hC8, 8'h80});
      repeat (4) drive(1, 0, 1, 1, 1, {8'h80, 8'hC8, 8'h80});
      repeat (10) drive(1, 0, 1, 1, 1, {8'h80, 8'h20, 8'h80});
      drive(1, 1, 1, 1, 1, {8'h80, 8'h6D, 8'h80});
      repeat (8) drive(1, 0, 1, 1, 1, {8'h80, 8'h20, 8'h80});
      @(negedge clk);
      check_bl("clamp_abort", 8'h6D);
      drive(1, 1, 1, 1, 1, {8'h80, 8'hFF, 8'h80});
`endif

      for (int i = 0; i < 20 && q.size() > 0; i++)
         @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
